aes_sub_bytes_iter: RTL and testbench

Iterative, parametrised AES SubBytes engine. It substitutes a word of `LANES` bytes through either the forward or the inverse AES S-box. Only `NSBOX` physical S-box pairs are instantiated, so one word takes `LANES/NSBOX` processing cycles. It sits between the round-key adder and ShiftRows in the round datapath and exchanges words over valid/ready handshakes on both sides.

---
 rtl/aes_sub_bytes_iter.sv | 210 +++++++++++++++++++++
 tb/tb_aes_sub_bytes_iter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sub_bytes_iter.sv
// Purpose: iterative AES SubBytes, forward or inverse S-box per word, NSBOX S-box pairs shared over LANES bytes.
// Latency: accept in cycle 0, BUSY for LANES/NSBOX cycles, out_valid first high in cycle LANES/NSBOX+1.
// Backpressure: DONE holds result and mode until out_ready; in_ready is combinational only from out_ready.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     input handshake; in_data (lane i = bits [8i+7:8i]) and in_inv sampled on accept
//   out_valid/out_ready   output handshake; out_data in the same lane order, out_inv = mode used
//   busy                  high while groups of lanes are being substituted

module aes_sub_bytes_iter #(
    parameter int LANES = 16,
    parameter int NSBOX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv,
    output logic               busy
);

    localparam int STEPS = LANES / NSBOX;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_GRP = CW'(STEPS - 1);

    // Exponent 254: x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
    localparam logic [7:0] INV_EXP = 8'hfe;

    generate
        if (LANES < 1 || LANES > 16) begin : g_bad_lanes
            $error("aes_sub_bytes_iter: LANES must be in 1..16");
        end
        if (NSBOX < 1 || (LANES % NSBOX) != 0) begin : g_bad_nsbox
            $error("aes_sub_bytes_iter: NSBOX must divide LANES");
        end
    endgenerate

    // ------------------------------------------------------------------
    // S-box arithmetic. The FIPS-197 tables are exactly affine(inverse(x))
    // and its inverse, so one GF inverter per lane serves both directions.
    // ------------------------------------------------------------------

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Square-and-multiply for x^254.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (INV_EXP[i]) begin
                r = gf_mul(r, s);
            end
            s = gf_mul(s, s);
        end
        return r;
    endfunction

    // Forward affine map: b_i = x_i ^ x_i+4 ^ x_i+5 ^ x_i+6 ^ x_i+7 ^ c_i, c = 0x63.
    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = 8'h00;
        for (int i = 0; i < 8; i++) begin
            y[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8];
        end
        return y ^ 8'h63;
    endfunction

    // Inverse affine map: x_i = b_i+2 ^ b_i+5 ^ b_i+7 ^ d_i, d = 0x05.
    function automatic logic [7:0] aff_inv(input logic [7:0] b);
        logic [7:0] y;
        y = 8'h00;
        for (int i = 0; i < 8; i++) begin
            y[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        return y ^ 8'h05;
    endfunction

    // One forward/inverse S-box pair sharing the inverter.
    function automatic logic [7:0] sbox_pair(input logic [7:0] x, input logic inv);
        logic [7:0] pre;
        logic [7:0] g;
        pre = inv ? aff_inv(x) : x;
        g   = gf_inv(pre);
        return inv ? g : aff_fwd(g);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [8*LANES-1:0] src;
    logic [8*LANES-1:0] res;
    logic               mode;
    logic [CW-1:0]      grp;

    logic               accept;
    logic [8*NSBOX-1:0] grp_src;
    logic [8*NSBOX-1:0] grp_sub;
    logic [8*LANES-1:0] res_next;

    // DONE with out_ready frees the result slot in the same cycle, which is
    // what lets a new word follow without an IDLE bubble.
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    assign out_data = res;
    assign out_inv  = mode;

    // Select the group of lanes handled this cycle.
    always_comb begin
        int base;
        base    = int'(grp) * 8 * NSBOX;
        grp_src = src[base +: 8*NSBOX];
    end

    generate
        for (genvar k = 0; k < NSBOX; k++) begin : g_sbox
            assign grp_sub[8*k +: 8] = sbox_pair(grp_src[8*k +: 8], mode);
        end
    endgenerate

    // Merge the substituted group into the result; other lanes keep their value.
    always_comb begin
        int base;
        base     = int'(grp) * 8 * NSBOX;
        res_next = res;
        res_next[base +: 8*NSBOX] = grp_sub;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grp       <= '0;
            src       <= '0;
            res       <= '0;
            mode      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        src   <= in_data;
                        mode  <= in_inv;
                        grp   <= '0;
                        state <= BUSY;
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    res <= res_next;
                    if (grp == LAST_GRP) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            src   <= in_data;
                            mode  <= in_inv;
                            grp   <= '0;
                            state <= BUSY;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Directed bench for aes_sub_bytes_iter across five (LANES, NSBOX) configurations.
// Index 0 is the default (16,4); 1..4 are (1,1), (16,16), (16,1), (8,2).

module tb_aes_sub_bytes_iter;

    localparam int NI = 5;
    localparam int LANES_A [NI] = '{16, 1, 16, 16, 8};
    localparam int NSBOX_A [NI] = '{4, 1, 16, 1, 2};
    localparam int LAT_A   [NI] = '{5, 2, 2, 17, 5};

    // FIPS-197 forward S-box, index 0 first.
    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    // Hand-written words, lane 0 in the low byte.
    localparam logic [127:0] W_SEQ    = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FWD_SEQ  = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [127:0] INV_SEQ  = 128'hfbd7f3819ea340bf38a53630d56a0952;
    localparam logic [127:0] W_SPOT   = 128'h0000000000000000000000000000ff53;
    localparam logic [127:0] FWD_SPOT = 128'h636363636363636363636363636316ed;

    logic           clk;
    logic           rst_n;
    logic [NI-1:0]  sw_in_valid;
    logic [NI-1:0]  sw_in_ready;
    logic [NI-1:0]  sw_inv;
    logic [NI-1:0]  sw_out_valid;
    logic [NI-1:0]  sw_out_ready;
    logic [NI-1:0]  sw_out_inv;
    logic [NI-1:0]  sw_busy;
    logic [127:0]   sw_in  [NI];
    logic [127:0]   sw_out [NI];

    int vectors;
    int miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int L = LANES_A[g];
        logic [8*L-1:0] od;
        aes_sub_bytes_iter #(.LANES(L), .NSBOX(NSBOX_A[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (sw_in_valid[g]),
            .in_ready  (sw_in_ready[g]),
            .in_data   (sw_in[g][8*L-1:0]),
            .in_inv    (sw_inv[g]),
            .out_valid (sw_out_valid[g]),
            .out_ready (sw_out_ready[g]),
            .out_data  (od),
            .out_inv   (sw_out_inv[g]),
            .busy      (sw_busy[g])
        );
        assign sw_out[g] = 128'(od);
    end

    function automatic logic [7:0] inv_sb(input logic [7:0] b);
        for (int i = 0; i < 256; i++) begin
            if (SBOX[i] == b) return 8'(i);
        end
        return 8'h00;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv, input int L);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < L; i++) begin
            r[8*i +: 8] = inv ? inv_sb(d[8*i +: 8]) : SBOX[d[8*i +: 8]];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Push one word through instance g and check latency, busy length, data and mode.
    // With rnd set, out_ready is randomised and the result is also held back a few cycles.
    task automatic run_word(input int g, input logic [127:0] d, input logic inv, input bit rnd,
                            input string tag, output logic [127:0] r);
        logic [127:0] exp;
        int lat;
        int bcnt;
        int w;
        exp = model(d, inv, LANES_A[g]);
        sw_in[g] = d;
        sw_inv[g] = inv;
        sw_in_valid[g] = 1'b1;
        sw_out_ready[g] = 1'b1;
        #1;
        w = 0;
        while (!sw_in_ready[g] && w < 50) begin
            step();
            w++;
        end
        step();
        sw_in_valid[g] = 1'b0;
        sw_in[g] = {$urandom, $urandom, $urandom, $urandom};
        sw_inv[g] = ~inv;
        lat = 1;
        bcnt = 0;
        while (!sw_out_valid[g] && lat < 40) begin
            if (sw_busy[g]) bcnt++;
            if (rnd) sw_out_ready[g] = 1'($urandom);
            step();
            lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'(LAT_A[g]));
        check({tag, "_busy"}, 128'(bcnt), 128'(LAT_A[g] - 1));
        check({tag, "_data"}, sw_out[g], exp);
        check({tag, "_inv"}, 128'(sw_out_inv[g]), 128'(inv));
        r = sw_out[g];
        if (rnd) begin
            sw_out_ready[g] = 1'b0;
            repeat ($urandom_range(1, 3)) step();
            check({tag, "_hold"}, {sw_out[g][126:0], sw_out_valid[g]}, {exp[126:0], 1'b1});
        end
        sw_out_ready[g] = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r;
        logic [127:0] r2;
        logic [127:0] d;
        int w;
        int lat;
        int vcnt;

        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        sw_in_valid = '0;
        sw_inv = '0;
        sw_out_ready = '0;
        for (int g = 0; g < NI; g++) sw_in[g] = '0;

        // Reset with random inputs for three cycles.
        for (int c = 0; c < 3; c++) begin
            sw_in_valid = NI'($urandom);
            sw_inv = NI'($urandom);
            sw_out_ready = NI'($urandom);
            for (int g = 0; g < NI; g++) sw_in[g] = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        check("rst_data", sw_out[0], '0);
        check("rst_ctl", 128'({sw_out_valid, sw_busy, sw_out_inv}), '0);
        sw_in_valid = '0;
        sw_out_ready = '1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 128'(sw_in_ready), 128'({NI{1'b1}}));

        // Forward mode, default configuration.
        run_word(0, W_SEQ, 1'b0, 1'b0, "fwd", r);
        check("fwd_const", r, FWD_SEQ);

        // Inverse round trip and a spot word.
        run_word(0, r, 1'b1, 1'b0, "inv", r2);
        check("inv_const", r2, W_SEQ);
        run_word(0, W_SPOT, 1'b0, 1'b0, "spot", r);
        check("spot_const", r, FWD_SPOT);

        // Backpressure in DONE, then a back-to-back accept.
        sw_in_valid[0] = 1'b0;
        sw_out_ready[0] = 1'b1;
        step();
        sw_in[0] = W_SEQ;
        sw_inv[0] = 1'b1;
        sw_in_valid[0] = 1'b1;
        sw_out_ready[0] = 1'b0;
        step();
        sw_in[0] = W_SPOT;
        sw_inv[0] = 1'b0;
        w = 0;
        while (!sw_out_valid[0] && w < 20) begin
            step();
            w++;
        end
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp_hold%0d", c),
                  {sw_out[0][124:0], sw_out_valid[0], sw_out_inv[0], sw_in_ready[0]},
                  {INV_SEQ[124:0], 1'b1, 1'b1, 1'b0});
            step();
        end
        check("bp_data_final", sw_out[0], INV_SEQ);
        sw_out_ready[0] = 1'b1;
        #1;
        check("b2b_in_ready", 128'(sw_in_ready[0]), 128'd1);
        step();
        sw_in[0] = {$urandom, $urandom, $urandom, $urandom};
        sw_inv[0] = 1'b1;
        sw_in_valid[0] = 1'b0;
        lat = 1;
        while (!sw_out_valid[0] && lat < 40) begin
            if (lat == 2) sw_in[0] = W_SEQ;
            step();
            lat++;
        end
        check("b2b_lat", 128'(lat), 128'd5);
        check("b2b_data", sw_out[0], FWD_SPOT);
        check("b2b_inv", 128'(sw_out_inv[0]), 128'd0);

        // Reset in the second BUSY cycle: the word must vanish.
        step();
        sw_in[0] = W_SEQ;
        sw_inv[0] = 1'b0;
        sw_in_valid[0] = 1'b1;
        #1;
        step();
        sw_in_valid[0] = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (sw_out_valid[0]) vcnt++;
            step();
        end
        check("midrst_no_valid", 128'(vcnt), 128'd0);
        check("midrst_busy", 128'(sw_busy[0]), 128'd0);
        run_word(0, W_SEQ, 1'b0, 1'b0, "midrst_next", r);
        check("midrst_next_const", r, FWD_SEQ);

        // Parameter sweep: every byte value forward through the table, then back to identity.
        for (int g = 1; g < NI; g++) begin
            for (int base = 0; base < 256; base += LANES_A[g]) begin
                d = '0;
                for (int i = 0; i < LANES_A[g]; i++) d[8*i +: 8] = 8'(base + i);
                run_word(g, d, 1'b0, 1'b0, $sformatf("sw%0d_f%0d", g, base), r);
                run_word(g, r, 1'b1, 1'b0, $sformatf("sw%0d_i%0d", g, base), r2);
                check($sformatf("sw%0d_rt%0d", g, base), r2, d);
            end
        end

        // Random traffic with random out_ready on every configuration.
        for (int g = 0; g < NI; g++) begin
            for (int n = 0; n < 12; n++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                run_word(g, d, 1'($urandom_range(0, 1)), 1'b1, $sformatf("rnd%0d_%0d", g, n), r);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
